// File: rtl/lms_pkg.sv
// Shared constants, FSM state encoding and tap beat layout for the LMS tap feeder
// and the MAC/update engine it feeds.
package lms_pkg;

    localparam int LMS_DATA_WIDTH = 16;
    localparam int LMS_TAPS       = 32;
    localparam int LMS_TAP_IDX_W  = 5;
    localparam int LMS_CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2
    } lms_state_e;

    typedef struct packed {
        logic [LMS_DATA_WIDTH-1:0] data;
        logic [LMS_TAP_IDX_W-1:0]  idx;
        logic                      first;
        logic                      last;
    } tap_beat_t;

endpackage

// File: rtl/lms_tap_line.sv
// TAPS x DATA_WIDTH register delay line: one write port, one combinational read
// port and a synchronous clear of every entry.
module lms_tap_line
    import lms_pkg::*;
#(
    parameter int DATA_WIDTH = LMS_DATA_WIDTH,
    parameter int TAPS       = LMS_TAPS,
    parameter int ADDR_W     = LMS_TAP_IDX_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] line_r [TAPS];

    // Sample storage: zeroed on reset or clear, otherwise one write per pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                line_r[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < TAPS; i++) begin
                line_r[i] <= '0;
            end
        end else if (we) begin
            line_r[waddr] <= wdata;
        end
    end

    assign rdata = line_r[raddr];

endmodule

// File: rtl/lms_tap_feeder.sv
// Pops samples from the prefetch FIFO into a circular delay line and streams the
// full tap window, newest first, to the LMS MAC over valid/ready.
module lms_tap_feeder
    import lms_pkg::*;
#(
    parameter int DATA_WIDTH = LMS_DATA_WIDTH,
    parameter int TAPS       = LMS_TAPS,
    parameter int TAP_IDX_W  = LMS_TAP_IDX_W,
    parameter int CNT_W      = LMS_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clear,
    output logic                  fifo_rd_en,
    input  logic                  fifo_rd_vld,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  tap_valid,
    input  logic                  tap_ready,
    output logic [DATA_WIDTH-1:0] tap_data,
    output logic [TAP_IDX_W-1:0]  tap_idx,
    output logic                  tap_first,
    output logic                  tap_last,
    output logic [CNT_W-1:0]      sample_cnt
);

    localparam logic [TAP_IDX_W-1:0] IDX_ONE  = TAP_IDX_W'(1);
    localparam logic [TAP_IDX_W-1:0] LAST_IDX = TAP_IDX_W'(TAPS - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

    lms_state_e            state_r;
    lms_state_e            state_nxt_s;
    logic                  pop_s;
    logic                  adv_s;
    logic                  done_s;
    logic [TAP_IDX_W-1:0]  wptr_r;
    logic [TAP_IDX_W-1:0]  newest_r;
    logic [TAP_IDX_W-1:0]  raddr_s;
    logic [TAP_IDX_W-1:0]  idx_nxt_s;
    logic [DATA_WIDTH-1:0] rdata_s;
    logic                  tap_valid_r;
    logic [DATA_WIDTH-1:0] tap_data_r;
    logic [TAP_IDX_W-1:0]  tap_idx_r;
    logic                  tap_first_r;
    logic                  tap_last_r;
    logic [CNT_W-1:0]      sample_cnt_r;

    // Address of the tap that follows the one currently presented.
    assign idx_nxt_s = tap_idx_r + IDX_ONE;
    assign raddr_s   = newest_r - tap_idx_r - IDX_ONE;

    lms_tap_line #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAPS       (TAPS),
        .ADDR_W     (TAP_IDX_W)
    ) u_line (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .we    (pop_s),
        .waddr (wptr_r),
        .wdata (fifo_rd_data),
        .raddr (raddr_s),
        .rdata (rdata_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and per-cycle events; clear overrides everything, so no pop on a clear cycle.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        adv_s       = 1'b0;
        done_s      = 1'b0;
        if (clear) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (en) begin
                        state_nxt_s = FETCH;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                FETCH: begin
                    if (fifo_rd_vld) begin
                        pop_s       = 1'b1;
                        state_nxt_s = STREAM;
                    end else begin
                        state_nxt_s = FETCH;
                    end
                end
                STREAM: begin
                    if (tap_ready && tap_last_r) begin
                        done_s      = 1'b1;
                        state_nxt_s = en ? FETCH : IDLE;
                    end else if (tap_ready) begin
                        adv_s = 1'b1;
                    end else begin
                        state_nxt_s = STREAM;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // Datapath: pointers, counter and the registered tap beat (held while stalled).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r       <= '0;
            newest_r     <= '0;
            sample_cnt_r <= '0;
            tap_valid_r  <= 1'b0;
            tap_data_r   <= '0;
            tap_idx_r    <= '0;
            tap_first_r  <= 1'b0;
            tap_last_r   <= 1'b0;
        end else if (clear) begin
            wptr_r       <= '0;
            newest_r     <= '0;
            sample_cnt_r <= '0;
            tap_valid_r  <= 1'b0;
            tap_data_r   <= '0;
            tap_idx_r    <= '0;
            tap_first_r  <= 1'b0;
            tap_last_r   <= 1'b0;
        end else if (pop_s) begin
            wptr_r       <= wptr_r + IDX_ONE;
            newest_r     <= wptr_r;
            sample_cnt_r <= sample_cnt_r + CNT_ONE;
            tap_valid_r  <= 1'b1;
            tap_data_r   <= fifo_rd_data;
            tap_idx_r    <= '0;
            tap_first_r  <= 1'b1;
            tap_last_r   <= 1'b0;
        end else if (adv_s) begin
            tap_data_r  <= rdata_s;
            tap_idx_r   <= idx_nxt_s;
            tap_first_r <= 1'b0;
            tap_last_r  <= (idx_nxt_s == LAST_IDX);
        end else if (done_s) begin
            tap_valid_r <= 1'b0;
            tap_last_r  <= 1'b0;
        end
    end

    assign fifo_rd_en = pop_s;
    assign tap_valid  = tap_valid_r;
    assign tap_data   = tap_data_r;
    assign tap_idx    = tap_idx_r;
    assign tap_first  = tap_first_r;
    assign tap_last   = tap_last_r;
    assign sample_cnt = sample_cnt_r;

endmodule
